// File: rtl/encoder_8_3_seq.sv
// Sequential 8-to-3 encoder.
// Rising edges on the request lines are captured into a pending set. One pending
// index at a time moves into a single-entry output register, which is presented
// over a valid/ready handshake. Selection is either fixed priority (lowest index
// first) or rotating (search starts just above the last index emitted).
module encoder_8_3_seq #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] in_req,
    output logic [2:0] code_out,
    output logic       code_valid,
    input  logic       code_ready,
    output logic [7:0] pending,
    output logic       lost,
    output logic       busy
);

    logic [7:0] prev_req;
    logic [2:0] last_idx;
    logic [7:0] rise;
    logic       load;
    logic       any_pend;
    logic [2:0] sel;
    logic [2:0] idx;
    logic       found;
    logic [7:0] take_mask;

    // Edge detect, output-stage availability and the bit leaving pending this cycle
    always_comb begin
        rise      = in_req & ~prev_req;
        load      = ~code_valid | code_ready;
        any_pend  = |pending;
        take_mask = (load && any_pend) ? (8'd1 << sel) : 8'd0;
        busy      = code_valid | any_pend;
    end

    // Pick the next index from the registered pending set only; new rises wait a cycle
    always_comb begin
        sel   = 3'd0;
        idx   = 3'd0;
        found = 1'b0;
        if (ROUND_ROBIN) begin
            // Walk last_idx+1 .. last_idx+8 modulo 8; the 3-bit add provides the wrap
            for (int i = 1; i <= 8; i++) begin
                idx = last_idx + 3'(i);
                if (!found && pending[idx]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end else begin
            // Scan high to low so the lowest set bit is the one left in sel
            for (int i = 7; i >= 0; i--) begin
                if (pending[i]) begin
                    sel = 3'(i);
                end
            end
        end
    end

    // Pending set, output register, rotation pointer and loss flag
    always_ff @(posedge sys_clk) begin
        prev_req <= in_req;
        if (sys_rst) begin
            code_out   <= 3'd0;
            code_valid <= 1'b0;
            pending    <= 8'd0;
            lost       <= 1'b0;
            last_idx   <= 3'd7;
        end else begin
            // A rise only counts as lost when its bit is already waiting and stays waiting
            lost    <= |(rise & pending & ~take_mask);
            pending <= (pending & ~take_mask) | rise;
            if (load) begin
                if (any_pend) begin
                    code_out   <= sel;
                    code_valid <= 1'b1;
                    last_idx   <= sel;
                end else begin
                    code_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_encoder_8_3_seq.sv
// Bench for encoder_8_3_seq: one fixed-priority and one rotating-priority instance
// share stimulus; each is compared every cycle against an event-level model.
module tb_encoder_8_3_seq;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [7:0] in_req;
    logic       code_ready;

    logic [2:0] code_out0, code_out1;
    logic       code_valid0, code_valid1;
    logic [7:0] pending0, pending1;
    logic       lost0, lost1;
    logic       busy0, busy1;

    always #5 sys_clk = ~sys_clk;

    encoder_8_3_seq #(.ROUND_ROBIN(1'b0)) dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_req(in_req),
        .code_out(code_out0), .code_valid(code_valid0), .code_ready(code_ready),
        .pending(pending0), .lost(lost0), .busy(busy0)
    );

    encoder_8_3_seq #(.ROUND_ROBIN(1'b1)) dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_req(in_req),
        .code_out(code_out1), .code_valid(code_valid1), .code_ready(code_ready),
        .pending(pending1), .lost(lost1), .busy(busy1)
    );

    int total = 0;
    int bad   = 0;

    // Reference state, one slot per instance (0 = fixed, 1 = rotating)
    bit m_pend[2][8];
    int m_code[2];
    bit m_valid[2];
    int m_last[2];
    bit m_lost[2];
    bit m_prev[8];

    int acc0[$];
    int acc1[$];
    int lost_cnt0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pend_vec(input int r);
        logic [7:0] v;
        v = 8'd0;
        for (int i = 0; i < 8; i++) if (m_pend[r][i]) v = v | (8'd1 << i);
        return v;
    endfunction

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        bit rise[8];
        bit ld;
        int take;
        int j;
        for (int i = 0; i < 8; i++) rise[i] = in_req[i] && !m_prev[i];
        for (int r = 0; r < 2; r++) begin
            if (sys_rst) begin
                for (int i = 0; i < 8; i++) m_pend[r][i] = 1'b0;
                m_code[r]  = 0;
                m_valid[r] = 1'b0;
                m_last[r]  = 7;
                m_lost[r]  = 1'b0;
            end else begin
                ld   = !m_valid[r] || code_ready;
                take = -1;
                if (ld) begin
                    for (int k = 0; k < 8; k++) begin
                        j = (r == 0) ? k : (m_last[r] + 1 + k) % 8;
                        if (take < 0 && m_pend[r][j]) take = j;
                    end
                end
                m_lost[r] = 1'b0;
                for (int i = 0; i < 8; i++)
                    if (rise[i] && m_pend[r][i] && i != take) m_lost[r] = 1'b1;
                for (int i = 0; i < 8; i++)
                    m_pend[r][i] = (m_pend[r][i] && i != take) || rise[i];
                if (ld) begin
                    if (take >= 0) begin
                        m_code[r]  = take;
                        m_valid[r] = 1'b1;
                        m_last[r]  = take;
                    end else begin
                        m_valid[r] = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < 8; i++) m_prev[i] = in_req[i];
    endtask

    // One clock: log handshakes, step the model, then compare after the edge
    task automatic cycle();
        if (code_ready && code_valid0 === 1'b1) acc0.push_back(int'(code_out0));
        if (code_ready && code_valid1 === 1'b1) acc1.push_back(int'(code_out1));
        model_step();
        @(posedge sys_clk);
        #1;
        chk("valid0", {31'd0, code_valid0}, {31'd0, m_valid[0]});
        chk("code0", {29'd0, code_out0}, m_code[0]);
        chk("pend0", {24'd0, pending0}, {24'd0, pend_vec(0)});
        chk("lost0", {31'd0, lost0}, {31'd0, m_lost[0]});
        chk("busy0", {31'd0, busy0}, {31'd0, m_valid[0] || (pend_vec(0) != 8'd0)});
        chk("valid1", {31'd0, code_valid1}, {31'd0, m_valid[1]});
        chk("code1", {29'd0, code_out1}, m_code[1]);
        chk("pend1", {24'd0, pending1}, {24'd0, pend_vec(1)});
        chk("lost1", {31'd0, lost1}, {31'd0, m_lost[1]});
        chk("busy1", {31'd0, busy1}, {31'd0, m_valid[1] || (pend_vec(1) != 8'd0)});
        if (lost0 === 1'b1) lost_cnt0++;
    endtask

    task automatic check_seq(input string tag, input int got[$], input int exp[$]);
        chk({tag, "_len"}, got.size(), exp.size());
        for (int k = 0; k < exp.size() && k < got.size(); k++)
            chk($sformatf("%s_%0d", tag, k), got[k], exp[k]);
    endtask

    initial begin
        sys_rst    = 1'b1;
        in_req     = 8'hFF;
        code_ready = 1'b1;
        lost_cnt0  = 0;

        // T1: lines held high through reset release produce no events
        cycle();
        cycle();
        sys_rst = 1'b0;
        repeat (3) cycle();
        chk("t1_pend", {24'd0, pending0}, 32'd0);
        chk("t1_valid", {31'd0, code_valid0}, 32'd0);

        // T2: single request on line 2
        in_req = 8'h00;
        cycle();
        in_req = 8'h04;
        cycle();
        chk("t2_pend", {24'd0, pending0}, 32'h04);
        chk("t2_valid_early", {31'd0, code_valid0}, 32'd0);
        cycle();
        chk("t2_code", {29'd0, code_out0}, 32'd2);
        chk("t2_valid", {31'd0, code_valid0}, 32'd1);
        cycle();
        chk("t2_idle", {31'd0, code_valid0}, 32'd0);

        // T3: burst A5, fixed gives 0,2,5,7; rotating (last=2) gives 5,7,0,2
        in_req = 8'h00;
        cycle();
        acc0.delete();
        acc1.delete();
        in_req = 8'hA5;
        repeat (6) cycle();
        check_seq("t3_fixed", acc0, '{0, 2, 5, 7});
        check_seq("t3_rr", acc1, '{5, 7, 0, 2});

        // T4: rotating with last_idx=2 and pending 81 gives 7 then 0
        sys_rst = 1'b1;
        in_req  = 8'h00;
        cycle();
        sys_rst = 1'b0;
        acc0.delete();
        acc1.delete();
        in_req = 8'h04;
        cycle();
        cycle();
        in_req = 8'h85;
        repeat (5) cycle();
        check_seq("t4_rr", acc1, '{2, 7, 0});
        check_seq("t4_fixed", acc0, '{2, 0, 7});

        // T5: re-rise of a waiting bit while stalled is dropped and flagged once
        in_req     = 8'h00;
        code_ready = 1'b0;
        repeat (2) cycle();
        acc0.delete();
        lost_cnt0 = 0;
        in_req = 8'h02;
        cycle();
        cycle();
        in_req = 8'h0A;
        cycle();
        in_req = 8'h02;
        cycle();
        in_req = 8'h0A;
        cycle();
        in_req = 8'h02;
        cycle();
        code_ready = 1'b1;
        repeat (4) cycle();
        check_seq("t5_codes", acc0, '{1, 3});
        chk("t5_lost_cnt", lost_cnt0, 32'd1);

        // T6: reset while stalled with work queued discards everything
        code_ready = 1'b0;
        in_req     = 8'h00;
        cycle();
        in_req = 8'h70;
        cycle();
        cycle();
        sys_rst = 1'b1;
        cycle();
        chk("t6_valid", {31'd0, code_valid0}, 32'd0);
        chk("t6_code", {29'd0, code_out0}, 32'd0);
        chk("t6_pend", {24'd0, pending1}, 32'd0);
        sys_rst    = 1'b0;
        code_ready = 1'b1;
        acc0.delete();
        acc1.delete();
        repeat (4) cycle();
        chk("t6_stale0", acc0.size(), 32'd0);
        chk("t6_stale1", acc1.size(), 32'd0);

        // Randomized traffic with sparse bit toggles, random back-pressure, rare resets
        for (int n = 0; n < 800; n++) begin
            in_req     = in_req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            code_ready = ($urandom_range(0, 3) != 0);
            sys_rst    = ($urandom_range(0, 149) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
